// File: rtl/ifetch_queue.sv
// In-order instruction fetch queue between the PC generator and decode, with flush-drop accounting.
// Optional build macro IFETCH_MISALIGN_CHK_EN: misaligned PCs are enqueued locally and flagged, with no memory request.
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_valid,
    input  logic [AW-1:0] pc,
    output logic          pc_ready,
    input  logic          flush,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [AW-1:0] instr_pc
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic          instr_misalign
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] alloc_q, alloc_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [AW-1:0]    pc_q   [DEPTH];
    logic [AW-1:0]    pc_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
`ifdef IFETCH_MISALIGN_CHK_EN
    logic [DEPTH-1:0] misalign_q, misalign_d;
    logic             pc_misaligned;
`endif

    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] fill_ptr_q, fill_ptr_d;
    logic [PW-1:0] head_ptr_q, head_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW:0]   drop_cnt_q, drop_cnt_d;

    logic          enq_try;
    logic          grant;
    logic          enq;
    logic          pop;
    logic [PW-1:0] fill_idx;
    logic          fill_ok;
    logic [PW:0]   unfilled;
    logic [PW+1:0] drop_sum;

    // Issue side: requests are credit-limited by the registered count only.
    always_comb begin
        enq_try = rst_n & pc_valid & ~flush & (count_q != FULL);
`ifdef IFETCH_MISALIGN_CHK_EN
        pc_misaligned = (pc[1:0] != 2'b00);
        imem_req      = enq_try & ~pc_misaligned;
        grant         = imem_req & imem_gnt;
        enq           = grant | (enq_try & pc_misaligned);
`else
        imem_req      = enq_try;
        grant         = imem_req & imem_gnt;
        enq           = grant;
`endif
        pc_ready  = enq;
        imem_addr = pc;
    end

    assign instr_valid = alloc_q[head_ptr_q] & filled_q[head_ptr_q];
    assign pop         = instr_valid & instr_ready;
    assign instr       = instr_valid ? data_q[head_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? pc_q[head_ptr_q]   : '0;
`ifdef IFETCH_MISALIGN_CHK_EN
    assign instr_misalign = instr_valid & misalign_q[head_ptr_q];
`endif

    // Response target: the oldest allocated entry still waiting for data.
    always_comb begin
        fill_idx = fill_ptr_q;
        fill_ok  = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        // Locally filled (misaligned) entries are skipped; lowest offset wins.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (alloc_q[fill_ptr_q + PW'(k)] & ~filled_q[fill_ptr_q + PW'(k)]) begin
                fill_idx = fill_ptr_q + PW'(k);
                fill_ok  = 1'b1;
            end
        end
`else
        fill_ok = alloc_q[fill_ptr_q] & ~filled_q[fill_ptr_q];
`endif
    end

    always_comb begin
        unfilled = '0;
        for (int i = 0; i < DEPTH; i++) begin
            unfilled = unfilled + (PW+1)'(alloc_q[i] & ~filled_q[i]);
        end
        drop_sum = (PW+2)'(drop_cnt_q) + (PW+2)'(unfilled);
        if (imem_rvalid && (drop_sum != '0)) begin
            drop_sum = drop_sum - (PW+2)'(1);
        end
    end

    always_comb begin
        alloc_d     = alloc_q;
        filled_d    = filled_q;
        pc_d        = pc_q;
        data_d      = data_q;
`ifdef IFETCH_MISALIGN_CHK_EN
        misalign_d  = misalign_q;
`endif
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q;
        drop_cnt_d  = drop_cnt_q;

        if (flush) begin
            // Every in-flight request becomes a response to discard later.
            alloc_d     = '0;
            filled_d    = '0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            count_d     = '0;
            drop_cnt_d  = drop_sum[PW:0];
        end else begin
            if (imem_rvalid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - (PW+1)'(1);
                end else if (fill_ok) begin
                    filled_d[fill_idx] = 1'b1;
                    data_d[fill_idx]   = imem_rdata;
                    fill_ptr_d         = fill_idx + PW'(1);
                end
            end
            // enq, fill and pop never target the same slot in one cycle.
            if (enq) begin
                alloc_d[alloc_ptr_q]  = 1'b1;
                pc_d[alloc_ptr_q]     = pc;
`ifdef IFETCH_MISALIGN_CHK_EN
                filled_d[alloc_ptr_q]   = pc_misaligned;
                misalign_d[alloc_ptr_q] = pc_misaligned;
                data_d[alloc_ptr_q]     = 32'h0;
`else
                filled_d[alloc_ptr_q] = 1'b0;
`endif
                alloc_ptr_d = alloc_ptr_q + PW'(1);
            end
            if (pop) begin
                alloc_d[head_ptr_q]  = 1'b0;
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(enq) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_q     <= '0;
            filled_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q  <= '0;
`endif
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
        end else begin
            alloc_q     <= alloc_d;
            filled_q    <= filled_d;
            pc_q        <= pc_d;
            data_q      <= data_d;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q  <= misalign_d;
`endif
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue: fetch, back-pressure, flush drops, async reset, misaligned PC.
module tb_ifetch_queue;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_valid = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          pc_ready;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic          instr_misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_valid    (pc_valid),
    .pc          (pc),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    .instr_misalign (instr_misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_valid    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc_idx;
    int grants;
    int pops;
    logic rsp_pend;
    logic [31:0] rsp_data;
    logic [31:0] e;

    // Reset state, with a PC offered so the request gating is exercised.
    pc_valid = 1'b1;
    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc_ready", 32'(pc_ready), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    idle_inputs();

    // Single fetch.
    tick();
    pc_valid = 1'b1; pc = 32'h0; imem_gnt = 1'b1;
    #1;
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_pc_ready", 32'(pc_ready), 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    #1;
    check("t1_pc_ready_after", 32'(pc_ready), 32'd0);
    check("t1_valid_early", 32'(instr_valid), 32'd0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_instr", instr, 32'h0000_0013);
    check("t1_instr_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1;
    check("t1_popped", 32'(instr_valid), 32'd0);
    check("t1_instr_zero", instr, 32'h0);

    // Back-pressure: five PCs, decode stalled until cycle 7.
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    pc_idx = 0; grants = 0; pops = 0; rsp_pend = 1'b0; rsp_data = '0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      tick();
      imem_rvalid = rsp_pend;
      imem_rdata  = rsp_data;
      pc_valid    = (pc_idx < 5);
      pc          = 32'(pc_idx * 4);
      imem_gnt    = 1'b1;
      instr_ready = (cyc >= 7);
      #1;
      if (cyc >= 4 && cyc <= 7) check("t2_req_full", 32'(imem_req), 32'd0);
      if (cyc == 6) check("t2_grants_held", 32'(grants), 32'd4);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("t2_extra_pop", instr_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("t2_pop_pc", instr_pc, e);
          check("t2_pop_data", instr, 32'h1000 + e);
        end
        pops++;
      end
      rsp_pend = pc_ready;
      rsp_data = 32'h1000 + pc;
      if (pc_ready) begin
        grants++;
        pc_idx++;
      end
    end
    tick();
    idle_inputs();
    check("t2_grants", 32'(grants), 32'd5);
    check("t2_pops", 32'(pops), 32'd5);
    check("t2_left", 32'(exp_q.size()), 32'd0);

    // Flush with two fetches in flight.
    tick();
    pc_valid = 1'b1; pc = 32'h10; imem_gnt = 1'b1;
    #1;
    check("t3_g1", 32'(pc_ready), 32'd1);
    tick();
    pc = 32'h14;
    #1;
    check("t3_g2", 32'(pc_ready), 32'd1);
    tick();
    flush = 1'b1; pc = 32'h18;
    #1;
    check("t3_flush_req", 32'(imem_req), 32'd0);
    check("t3_flush_ready", 32'(pc_ready), 32'd0);
    tick();
    flush = 1'b0; pc = 32'h100;
    #1;
    check("t3_post_flush_ready", 32'(pc_ready), 32'd1);
    check("t3_post_flush_valid", 32'(instr_valid), 32'd0);
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
    #1;
    check("t3_valid_a", 32'(instr_valid), 32'd0);
    tick();
    imem_rdata = 32'hBBBB_0002;
    #1;
    check("t3_valid_b", 32'(instr_valid), 32'd0);
    tick();
    imem_rdata = 32'hCCCC_0003;
    #1;
    check("t3_valid_c", 32'(instr_valid), 32'd0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_instr", instr, 32'hCCCC_0003);
    check("t3_instr_pc", instr_pc, 32'h100);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1;
    check("t3_popped", 32'(instr_valid), 32'd0);

    // Flush coinciding with the only outstanding response.
    tick();
    pc_valid = 1'b1; pc = 32'h200; imem_gnt = 1'b1;
    #1;
    check("t4_grant", 32'(pc_ready), 32'd1);
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDDDD_0004;
    tick();
    flush = 1'b0; imem_rvalid = 1'b0; pc_valid = 1'b1; pc = 32'h300; imem_gnt = 1'b1;
    #1;
    check("t4_post_flush_valid", 32'(instr_valid), 32'd0);
    check("t4_grant2", 32'(pc_ready), 32'd1);
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hEEEE_0005;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("t4_valid", 32'(instr_valid), 32'd1);
    check("t4_instr", instr, 32'hEEEE_0005);
    check("t4_instr_pc", instr_pc, 32'h300);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Asynchronous reset with three filled entries.
    tick();
    pc_valid = 1'b1; pc = 32'h40; imem_gnt = 1'b1;
    tick();
    pc = 32'h44; imem_rvalid = 1'b1; imem_rdata = 32'h5000_0040;
    tick();
    pc = 32'h48; imem_rdata = 32'h5000_0044;
    tick();
    pc = 32'h4C; imem_gnt = 1'b0; imem_rdata = 32'h5000_0048;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("t5_valid_before", 32'(instr_valid), 32'd1);
    check("t5_head_pc", instr_pc, 32'h40);
    check("t5_req_before", 32'(imem_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_valid_async", 32'(instr_valid), 32'd0);
    check("t5_req_async", 32'(imem_req), 32'd0);
    check("t5_instr_async", instr, 32'h0);
    check("t5_pc_async", instr_pc, 32'h0);
    idle_inputs();
    tick();
    rst_n = 1'b1;

    // Misaligned PC.
    tick();
    pc_valid = 1'b1; pc = 32'h6; imem_gnt = 1'b0;
    #1;
`ifdef IFETCH_MISALIGN_CHK_EN
    check("t6_req", 32'(imem_req), 32'd0);
    check("t6_pc_ready", 32'(pc_ready), 32'd1);
    tick();
    pc_valid = 1'b0;
    #1;
    check("t6_valid", 32'(instr_valid), 32'd1);
    check("t6_misalign", 32'(instr_misalign), 32'd1);
    check("t6_instr", instr, 32'h0);
    check("t6_instr_pc", instr_pc, 32'h6);
`else
    check("t6_req", 32'(imem_req), 32'd1);
    check("t6_addr", imem_addr, 32'h6);
    check("t6_pc_ready", 32'(pc_ready), 32'd0);
    tick();
    pc_valid = 1'b0;
    #1;
    check("t6_valid", 32'(instr_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
